// File: rtl/data_mem_hs_pkg.sv
// Shared constants for the byte-addressed LSU data memory: RV32 funct3
// load/store encodings, FSM state encoding and the wait-state limit.
package data_mem_hs_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  localparam int MAX_WAIT_CYCLES = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response bus between the LSU (master) and the data memory (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid must not depend on ready, and once raised the producer holds
// valid and its payload stable until that transfer edge.
interface data_mem_hs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WORD_WIDTH-1:0] resp_rdata;
  logic                  resp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/data_mem_hs_lsu_lane_align.sv
// Byte-lane steering for RV32 loads and stores: per-lane write enables,
// lane-shifted store data, extended load data, and the funct3/alignment fault.
module lsu_lane_align
  import data_mem_hs_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        op_fault
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Decode the access size, steer lanes and extend the loaded value.
  always_comb begin
    byte_en    = '0;
    rdata_ext  = '0;
    op_fault   = 1'b0;
    wdata_lane = wdata << {offset, 3'b000};
    case (offset)
      2'd0:    lane_byte = rdata_word[7:0];
      2'd1:    lane_byte = rdata_word[15:8];
      2'd2:    lane_byte = rdata_word[23:16];
      default: lane_byte = rdata_word[31:24];
    endcase
    // offset[0] set is a halfword fault, so only the upper/lower half matter
    lane_half = offset[1] ? rdata_word[31:16] : rdata_word[15:0];
    case (funct3)
      FUNCT3_LB: begin
        byte_en   = 4'b0001 << offset;
        rdata_ext = {{24{lane_byte[7]}}, lane_byte};
      end
      FUNCT3_LH: begin
        op_fault  = offset[0];
        byte_en   = 4'b0011 << offset;
        rdata_ext = {{16{lane_half[15]}}, lane_half};
      end
      FUNCT3_LW: begin
        op_fault  = (offset != 2'd0);
        byte_en   = 4'b1111;
        rdata_ext = rdata_word;
      end
      FUNCT3_LBU: begin
        op_fault  = we;
        rdata_ext = {24'b0, lane_byte};
      end
      FUNCT3_LHU: begin
        op_fault  = we | offset[0];
        rdata_ext = {16'b0, lane_half};
      end
      default: op_fault = 1'b1;
    endcase
    if (op_fault) begin
      byte_en   = '0;
      rdata_ext = '0;
    end
  end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressed data memory with valid/ready request and response channels
// and WAIT_CYCLES wait states between accept and commit. One access at a time.
module data_mem_hs
  import data_mem_hs_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_hs_if.slave   bus,
  output state_e         dbg_state
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  if (WORD_WIDTH != 32) begin : g_bad_width
    $error("data_mem_hs: WORD_WIDTH must be 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_mem_hs: DEPTH must be a power of 2");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_wait
    $error("data_mem_hs: WAIT_CYCLES out of range");
  end

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  fault_q, fault_d;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            offset;
  logic                  range_fault;
  logic                  op_fault;
  logic                  access_fault;
  logic [3:0]            lane_be;
  logic [31:0]           wdata_lane;
  logic [31:0]           rdata_ext;
  logic                  mem_wr;

  assign word_idx     = addr_q[IDX_W+1:2];
  assign offset       = addr_q[1:0];
  assign range_fault  = (addr_q >> (IDX_W + 2)) != '0;
  assign access_fault = range_fault | op_fault;
  // A store committing in the same cycle as reset is dropped.
  assign mem_wr       = (state_q == EXEC) && we_q && !access_fault && !rst;

  lsu_lane_align u_align (
    .we         (we_q),
    .funct3     (f3_q),
    .offset     (offset),
    .wdata      (wdata_q),
    .rdata_word (mem[word_idx]),
    .byte_en    (lane_be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .op_fault   (op_fault)
  );

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
  assign dbg_state      = state_q;

  // Next-state and next-output logic for the access FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    fault_d      = fault_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          f3_d        = bus.req_funct3;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          state_d     = (WAIT_CYCLES > 0) ? WAIT : EXEC;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          cnt_d   = '0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      EXEC: begin
        fault_d      = access_fault;
        rdata_d      = (access_fault || we_q) ? '0 : rdata_ext;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, request latches and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
    end
  end

  // Per-lane store commit; memory contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_wr && lane_be[i]) begin
        mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

endmodule
